// File: rtl/unified_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_sequencer
// Purpose  : Shares one byte-wide RAM between instruction fetch and load/store.
//            Each 32-bit access becomes big-endian byte beats. Defining
//            MEM_SEQ_RR_EN selects round-robin arbitration instead of fixed
//            MEM-over-IF priority.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic              mem_size,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              busy,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_xfer = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;
    localparam logic       c_own_if  = 1'b0;
    localparam logic       c_own_mem = 1'b1;

    logic [1:0]        r_state;
    logic [1:0]        r_beat;
    logic              r_owner;
    logic              r_rw;
    logic              r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_acc;

    logic              w_grant;
    logic              w_grant_mem;
    logic              w_is_last;
    logic [7:0]        w_wbyte;
    logic              w_xfer;
    logic              w_unused;

    assign w_unused = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};
    assign w_grant  = if_req | mem_req;

`ifdef MEM_SEQ_RR_EN
    logic r_last_owner;

    // On contention the grant alternates away from whoever was served last.
    always_comb begin
        w_grant_mem = mem_req;
        if (mem_req && if_req) begin
            w_grant_mem = (r_last_owner == c_own_if);
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_last_owner <= c_own_if;
        end else if (r_state == c_st_idle && w_grant) begin
            r_last_owner <= w_grant_mem;
        end
    end
`else
    assign w_grant_mem = mem_req;
`endif

    // Fetches are latched as word reads, so size alone decides the final beat.
    assign w_is_last = (r_beat == (r_size ? 2'd3 : 2'd0));

    always_comb begin
        w_wbyte = r_wdata[7:0];
        if (r_size) begin
            case (r_beat)
                2'd0:    w_wbyte = r_wdata[31:24];
                2'd1:    w_wbyte = r_wdata[23:16];
                2'd2:    w_wbyte = r_wdata[15:8];
                default: w_wbyte = r_wdata[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state <= c_st_idle;
            r_beat  <= 2'd0;
            r_owner <= c_own_if;
            r_rw    <= 1'b0;
            r_size  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_acc   <= 32'h0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_grant) begin
                        r_owner <= w_grant_mem;
                        r_rw    <= w_grant_mem ? mem_rw : 1'b0;
                        r_size  <= w_grant_mem ? mem_size : 1'b1;
                        r_addr  <= w_grant_mem ? mem_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
                        r_wdata <= w_grant_mem ? mem_wdata : 32'h0;
                        r_acc   <= 32'h0;
                        r_beat  <= 2'd0;
                        r_state <= c_st_xfer;
                    end
                end
                c_st_xfer: begin
                    if (!r_rw) begin
                        r_acc <= {r_acc[23:0], ram_rdata};
                    end
                    if (w_is_last) begin
                        r_state <= c_st_resp;
                    end else begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign w_xfer    = (r_state == c_st_xfer);
    assign ram_addr  = w_xfer ? (r_addr + ADDR_W'(r_beat)) : '0;
    assign ram_we    = w_xfer & r_rw;
    assign ram_wdata = ram_we ? w_wbyte : 8'h00;

    assign if_ready  = (r_state == c_st_resp) && (r_owner == c_own_if);
    assign mem_ready = (r_state == c_st_resp) && (r_owner == c_own_mem);
    assign if_rdata  = if_ready ? r_acc : 32'h0;
    assign mem_rdata = (mem_ready && !r_rw) ? r_acc : 32'h0;

    assign busy      = (r_state != c_st_idle);
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_sequencer.sv
`default_nettype none
// Bench for unified_mem_sequencer: transaction-level model checked every cycle,
// plus directed accesses with hand-computed results.
module tb_unified_mem_sequencer;

    logic        clk = 1'b0;
    logic        Reset;
    logic        if_req, mem_req, mem_rw, mem_size;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_ready, mem_ready;
    logic [7:0]  ram_addr, ram_wdata, ram_rdata;
    logic        ram_we, busy, stall_if, stall_mem;

    logic [7:0]  ram  [256];
    logic [7:0]  mref [256];
    logic        pl_we;
    logic [7:0]  pl_addr, pl_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    unified_mem_sequencer #(.ADDR_W(8)) dut (
        .clk(clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) begin
        if (ram_we)      ram[ram_addr] <= ram_wdata;
        else if (pl_we)  ram[pl_addr]  <= pl_data;
    end

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Transaction-level model: a granted access owns the RAM for n beats, then
    // one response cycle, then at least one idle cycle.
    bit          m_valid = 0, m_busy = 0, m_last = 0;
    bit          m_owner, m_rw, m_size;
    int          m_off;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;

    initial begin
        int          n, bi;
        logic [7:0]  a, e_addr, e_wd;
        logic [31:0] rd, e_ifd, e_memd;
        logic        e_ifr, e_memr, e_we, e_sif, e_smem;
        forever begin
            @(negedge clk);
            e_we = 0; e_addr = 0; e_wd = 0;
            n = m_size ? 4 : 1;
            if (m_valid) begin
                e_ifr = 0; e_memr = 0; e_ifd = 0; e_memd = 0;
                if (m_busy) begin
                    if (m_off <= n) begin
                        bi = m_off - 1;
                        e_addr = m_addr + 8'(bi);
                        if (m_rw) begin
                            e_we = 1;
                            e_wd = m_size ? m_wdata[8*(3-bi) +: 8] : m_wdata[7:0];
                        end
                    end else begin
                        rd = 0;
                        if (!m_rw) begin
                            for (int k = 0; k < n; k++) begin
                                a  = m_addr + 8'(k);
                                rd = {rd[23:0], mref[a]};
                            end
                        end
                        if (m_owner) begin e_memr = 1; e_memd = rd; end
                        else         begin e_ifr  = 1; e_ifd  = rd; end
                    end
                end
                e_sif  = if_req & ~e_ifr;
                e_smem = mem_req & ~e_memr;
                chk("cycle_outputs",
                    96'({if_ready, mem_ready, busy, stall_if, stall_mem, ram_we, ram_addr,
                         ram_wdata, if_rdata, mem_rdata}),
                    96'({e_ifr, e_memr, m_busy, e_sif, e_smem, e_we, e_addr,
                         e_wd, e_ifd, e_memd}));
            end
            if (pl_we) mref[pl_addr] = pl_data;
            if (e_we)  mref[e_addr]  = e_wd;
            if (!Reset) begin
                m_valid = 1; m_busy = 0; m_last = 0;
            end else if (m_valid) begin
                if (m_busy) begin
                    if (m_off == n + 1) m_busy = 0;
                    else                m_off++;
                end else if (mem_req || if_req) begin
`ifdef MEM_SEQ_RR_EN
                    m_owner = (mem_req && if_req) ? !m_last : mem_req;
`else
                    m_owner = mem_req;
`endif
                    m_last  = m_owner;
                    m_rw    = m_owner ? mem_rw : 1'b0;
                    m_size  = m_owner ? mem_size : 1'b1;
                    m_addr  = m_owner ? mem_addr[7:0] : if_addr[7:0];
                    m_wdata = m_owner ? mem_wdata : 32'h0;
                    m_busy  = 1;
                    m_off   = 1;
                end
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_we = 1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 0;
    endtask

    // Called just after a rising edge; cycle 0 is the issue cycle.
    task automatic access(input bit own_mem, input bit rw, input bit size,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        int start;
        bit seen;
        start = cyc; seen = 0; rd = 0; lat = -1;
        if (own_mem) begin
            mem_req = 1; mem_rw = rw; mem_size = size; mem_addr = addr; mem_wdata = wd;
        end else begin
            if_req = 1; if_addr = addr;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (own_mem ? mem_ready : if_ready) begin
                seen = 1;
                rd   = own_mem ? mem_rdata : if_rdata;
                lat  = cyc - start;
            end
        end
        @(posedge clk); #1;
        if (own_mem) begin
            mem_req = 0; mem_rw = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
        end else begin
            if_req = 0; if_addr = 0;
        end
        chk("ready_seen", 96'(seen), 96'd1);
    endtask

    logic [31:0] rd_a, rd_b;
    int          lat_a, lat_b;
    bit          rst_ready;
    int          bad;

    initial begin
        Reset = 0; pl_we = 0; pl_addr = 0; pl_data = 0;
        if_req = 0; if_addr = 0;
        mem_req = 0; mem_rw = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
        repeat (3) @(posedge clk);
        #1 Reset = 1;

        preload(8'h00, 8'hE0); preload(8'h01, 8'h82); preload(8'h02, 8'h50); preload(8'h03, 8'h05);
        preload(8'h10, 8'h00);
        preload(8'h20, 8'hDE); preload(8'h21, 8'hAD); preload(8'h22, 8'hBE); preload(8'h23, 8'hEF);
        preload(8'h24, 8'h9A); preload(8'h25, 8'hBC);
        preload(8'h30, 8'h01); preload(8'h31, 8'h23); preload(8'h32, 8'h45); preload(8'h33, 8'h67);
        for (int i = 0; i < 4; i++) preload(8'h40 + 8'(i), 8'h00);
        @(posedge clk); #1;

        access(0, 0, 1, 32'h0000_0000, 32'h0, rd_a, lat_a);
        chk("fetch_word_data", 96'(rd_a), 96'hE082_5005);
        chk("fetch_word_lat",  96'(lat_a), 96'd5);

        access(1, 1, 0, 32'h0000_0010, 32'h1234_56AB, rd_a, lat_a);
        chk("store_byte_rdata", 96'(rd_a), 96'h0);
        chk("store_byte_lat",   96'(lat_a), 96'd2);
        access(1, 0, 0, 32'h0000_0010, 32'h0, rd_a, lat_a);
        chk("load_byte_data", 96'(rd_a), 96'h0000_00AB);
        chk("load_byte_lat",  96'(lat_a), 96'd2);

        access(1, 1, 1, 32'hFFFF_FFFE, 32'h1122_3344, rd_a, lat_a);
        chk("wrap_write_lat", 96'(lat_a), 96'd5);
        chk("wrap_byte_fe", 96'(ram[8'hFE]), 96'h11);
        chk("wrap_byte_ff", 96'(ram[8'hFF]), 96'h22);
        chk("wrap_byte_00", 96'(ram[8'h00]), 96'h33);
        chk("wrap_byte_01", 96'(ram[8'h01]), 96'h44);
        access(1, 0, 1, 32'h0000_00FE, 32'h0, rd_a, lat_a);
        chk("wrap_read_data", 96'(rd_a), 96'h1122_3344);

        fork
            access(1, 0, 1, 32'h0000_0020, 32'h0, rd_a, lat_a);
            access(0, 0, 1, 32'h0000_0030, 32'h0, rd_b, lat_b);
        join
        chk("contend_mem_data", 96'(rd_a), 96'hDEAD_BEEF);
        chk("contend_if_data",  96'(rd_b), 96'h0123_4567);
`ifndef MEM_SEQ_RR_EN
        chk("contend_mem_lat", 96'(lat_a), 96'd5);
        chk("contend_if_lat",  96'(lat_b), 96'd11);
`endif

        access(0, 0, 1, 32'h0000_0022, 32'h0, rd_a, lat_a);
        chk("misaligned_fetch", 96'(rd_a), 96'hBEEF_9ABC);
        access(1, 0, 0, 32'h0000_0021, 32'h0, rd_a, lat_a);
        chk("byte_load_21", 96'(rd_a), 96'h0000_00AD);

        // Word write aborted by reset sampled at the edge ending beat 1.
        rst_ready = 0;
        mem_req = 1; mem_rw = 1; mem_size = 1; mem_addr = 32'h40; mem_wdata = 32'hAABB_CCDD;
        repeat (2) begin
            @(negedge clk); if (mem_ready) rst_ready = 1;
            @(posedge clk);
        end
        #1 Reset = 0; mem_req = 0; mem_rw = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
        @(negedge clk); if (mem_ready) rst_ready = 1;
        @(posedge clk); #1 Reset = 1;
        @(negedge clk);
        chk("rst_busy",     96'(busy), 96'd0);
        chk("rst_ram_we",   96'(ram_we), 96'd0);
        chk("rst_no_ready", 96'({rst_ready, mem_ready}), 96'd0);
        repeat (6) begin
            @(negedge clk); if (mem_ready) rst_ready = 1;
        end
        chk("rst_no_late_ready", 96'(rst_ready), 96'd0);
        chk("rst_byte_40", 96'(ram[8'h40]), 96'hAA);
        chk("rst_byte_41", 96'(ram[8'h41]), 96'hBB);
        chk("rst_byte_42", 96'(ram[8'h42]), 96'h00);
        chk("rst_byte_43", 96'(ram[8'h43]), 96'h00);

        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== mref[i]) bad++;
        chk("ram_vs_model", 96'(bad), 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
